// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   fetch_state_t : fetch FSM states (RUN, HALT)
//   if_id_t       : IF/ID pipeline register contents
//   INSTR_NOP     : instruction word shown while IF/ID holds a bubble
//   ADDR_W        : byte-address width
//   pc_in_range   : aligned and whole word inside the ROM, without wrap
package cpu_pkg;

    localparam int          ADDR_W    = 64;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    // pc + 3 < imem_size is rewritten as pc < imem_size - 3 so that a PC near
    // 2^64 cannot wrap around and look in range. imem_size > 4 keeps the
    // subtraction positive.
    function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc,
                                         input logic [ADDR_W-1:0] imem_size);
        return (pc[1:0] == 2'b00) && (pc < (imem_size - ADDR_W'(3)));
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction ROM port of the fetch stage.
//   imem_address     : byte address presented to the ROM (copy of the PC)
//   imem_instruction : word returned combinationally by the ROM
// master = fetch stage, slave = ROM.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_instruction;

    modport master (output imem_address, input  imem_instruction);
    modport slave  (input  imem_address, output imem_instruction);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register.
//   clk, reset : clock, synchronous active-high reset to RESET_PC
//   load_en    : load load_value on this edge
//   load_value : next PC chosen by the fetch stage
//   pc         : current PC
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_value;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the ROM and captures the
// returned word into the IF/ID register.
//   clk, reset        : clock, synchronous active-high reset
//   stall             : hold PC, IF/ID and fetch_count
//   redirect          : load redirect_pc (word aligned) and flush IF/ID
//   redirect_pc       : branch target byte address
//   imem              : ROM port (address out, instruction in)
//   if_id_instr/pc/pc_plus4/valid : IF/ID register
//   halted            : fetch stopped because the PC left the ROM
//   fetch_count       : valid instructions captured since reset (wraps)
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'd0,
    parameter int unsigned       IMEM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     imem,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_SIZE);

    fetch_state_t      state;
    if_id_t            if_id;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_target;
    logic              pc_ok;
    logic              target_ok;
    logic              pc_load_en;
    logic [ADDR_W-1:0] pc_load_value;

    assign pc_plus4        = pc + ADDR_W'(4);
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign pc_ok           = pc_in_range(pc, IMEM_BYTES);
    assign target_ok       = pc_in_range(redirect_target, IMEM_BYTES);

    // Next-PC select; reset is applied inside pc_reg and overrides this.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        pc_load_en    = 1'b0;
        pc_load_value = pc_plus4;
        if (redirect) begin
            pc_load_en    = 1'b1;
            pc_load_value = redirect_target;
        end else if (!stall && state == RUN && pc_ok) begin
            pc_load_en = 1'b1;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_en    (pc_load_en),
        .load_value (pc_load_value),
        .pc         (pc)
    );

    // FSM, IF/ID register and fetch counter. Priority: reset > redirect >
    // stall > normal fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            if_id       <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Flush: the slot after a redirect is always a bubble.
            if_id.valid <= 1'b0;
            if_id.instr <= INSTR_NOP;
            state       <= target_ok ? RUN : HALT;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (pc_ok) begin
                        if_id.instr    <= imem.imem_instruction;
                        if_id.pc       <= pc;
                        if_id.pc_plus4 <= pc_plus4;
                        if_id.valid    <= 1'b1;
                        fetch_count    <= fetch_count + 32'd1;
                    end else begin
                        if_id.valid <= 1'b0;
                        if_id.instr <= INSTR_NOP;
                        state       <= HALT;
                    end
                end
                HALT: begin
                    if_id.valid <= 1'b0;
                    if_id.instr <= INSTR_NOP;
                end
                default: state <= HALT;
            endcase
        end
    end

    assign imem.imem_address = pc;
    assign if_id_instr       = if_id.instr;
    assign if_id_pc          = if_id.pc;
    assign if_id_pc_plus4    = if_id.pc_plus4;
    assign if_id_valid       = if_id.valid;
    assign halted            = (state == HALT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the address port of the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register with its PC and PC+4. It sits directly upstream of decode and directly drives the instruction ROM. It also takes stall, redirect and flush requests from later stages and halts cleanly when the PC leaves the ROM.

## Interface
Parameters:
- RESET_PC, 64'd0, PC loaded on reset.
- IMEM_SIZE, 1024, instruction ROM size in bytes (power of two, > 4).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard stall from decode: hold PC and IF/ID.
- redirect  in  1  taken branch / BR resolved downstream.
- redirect_pc  in  64  branch target, byte address.
- imem_address  out  64  to instruction ROM; combinational copy of PC.
- imem_instruction  in  32  from instruction ROM (combinational read).
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  64  registered PC of if_id_instr.
- if_id_pc_plus4  out  64  registered if_id_pc + 4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped, PC out of range.
- fetch_count  out  32  number of valid instructions captured since reset.

## Operation
- State machine with two states:
  - RUN: fetch every unstalled cycle.
  - HALT: no fetch; imem_address still equals PC.
- In-range test: PC[1:0]==0 and PC+3 < IMEM_SIZE, computed in 64-bit unsigned arithmetic with no wrap.
- Priority per cycle: reset > redirect > stall > normal.
- Reset: PC=RESET_PC, state=RUN, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, halted=0, fetch_count=0.
- Redirect, in any state and regardless of stall:
  - PC ← {redirect_pc[63:2],2'b00}.
  - IF/ID flushed: valid=0, instr=0.
  - State ← RUN if the new PC is in range, else HALT.
- Stall without redirect: PC, IF/ID and fetch_count all hold.
- Normal, RUN, PC in range:
  - IF/ID ← {imem_instruction, PC, PC+4}, valid=1.
  - PC ← PC+4.
  - fetch_count increments, wrapping modulo 2^32.
- Normal, RUN, PC out of range: IF/ID valid ← 0, state ← HALT, PC holds.
- HALT without redirect: PC holds, IF/ID valid ← 0, fetch_count holds.
- Outputs:
  - halted = (state == HALT).
  - When if_id_valid=0, if_id_instr is always 0; if_id_pc and if_id_pc_plus4 are don't-care.
- An X on imem_instruction while fetching in range is passed through unmodified. An X on imem_address is never allowed; the PC is always defined after reset.

## Timing
- Single clock domain; no multicycle paths.
- ROM read is combinational: the word at PC is captured at the same posedge that advances the PC.
- Fetch-to-decode latency: 1 cycle.
- Redirect asserted in cycle N:
  - Target presented on imem_address in cycle N+1.
  - Target's instruction valid on IF/ID in cycle N+2.
  - The IF/ID slot for cycle N+1 is a bubble.
- Stall asserted for k cycles: IF/ID output is unchanged for those k cycles; fetch resumes the cycle after stall drops.
- Halt: the last in-range instruction is captured normally; halted rises on the edge after PC reaches the out-of-range address.
- Reset asserted mid-operation overrides every input on that edge; the first fetch from RESET_PC is valid in the cycle after reset deasserts.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t enum {RUN, HALT}.
  - if_id_t struct {instr, pc, pc_plus4, valid}.
  - INSTR_NOP = 32'h0.
  - Width constant ADDR_W = 64.
- One sub-module is natural: pc_reg. It holds the 64-bit PC register with a load-enable and load-value, fed by the next-PC select logic in fetch_stage.
- The IF/ID register, FSM and fetch_count live in fetch_stage.

## Test plan
- Reset, then 4 free-running cycles with ROM words 0x91000421, 0x91000842, 0x91000C63, 0x91001084: IF/ID shows PCs 0, 4, 8, 12 with those words, valid=1, fetch_count=4.
- Stall high 3 cycles while IF/ID holds PC 8: if_id_pc stays 8, imem_address stays 12, fetch_count is unchanged; next capture after release is PC 12.
- Redirect to 0x40 together with stall in the same cycle: the redirect wins. Next cycle imem_address=0x40 and valid=0; the cycle after, if_id_pc=0x40 with valid=1.
- Free-run to PC 0x3FC with IMEM_SIZE=1024: 0x3FC is captured valid; PC becomes 0x400, then halted=1 and valid=0 thereafter; fetch_count stops.
- While halted, redirect to 0x10: halted=0 the next cycle and PC 0x10 is fetched valid the cycle after. Separately, redirect to 0x800: halted=1 and the PC holds 0x800.
- Reset asserted mid-run at PC 0x20: on the next edge PC=RESET_PC, valid=0, fetch_count=0, halted=0.
